// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: opcodes, states, mux encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package multicycle_controller_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC     = 4'd7,
        S_R_WB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_TRAP     = 4'd11
    } state_e;

    // ALU operand B select
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // ALU operation select
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Next-PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       zero_inv;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: opcode/mem_ready in, control word and debug state out.
// Latency: n/a (wiring only).
// Backpressure: mem_ready is the memory port's completion handshake.
interface multicycle_controller_if;
    import multicycle_controller_pkg::*;

    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       zero_inv;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    state_e     state;

    // Controller side
    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, zero_inv, iord, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_source, state
    );

    // Datapath / memory side
    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, zero_inv, iord, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_source, state
    );
endinterface

// File: rtl/multicycle_output_decode.sv
// Pure combinational state -> control word decode (Moore, plus mem_ready gating in FETCH).
// Latency: 0 cycles, combinational.
// Backpressure: ir_write/pc_write in FETCH only fire on the mem_ready cycle.
module multicycle_output_decode
    import multicycle_controller_pkg::*;
(
    input  state_e state_i,
    input  logic   mem_ready_i,
    input  logic   zero_sel_i,    // opcode[0]: distinguishes bne from beq
    output ctrl_t  ctrl_o
);

    // Control word per state; IDLE and TRAP fall through to all-zero
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                // Only latch IR and bump PC once the instruction word has arrived
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMM_SH2;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            S_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REG;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_REG;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
                ctrl_o.zero_inv      = zero_sel_i;
            end
            S_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS sequencer (FETCH/DECODE/EXEC/MEM/WB); MULTICYCLE_ILLEGAL_TRAP_EN traps bad opcodes.
// Latency: R 4, lw 5, sw 4, beq/bne 3, j 3 cycles, plus 1 per memory wait cycle.
// Backpressure: FETCH, MEM_RD and MEM_WR hold (strobes asserted) until mem_ready.
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    multicycle_controller_if.master bus
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl;

    // State register; async reset drops any in-flight strobe immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state; opcode is stable from the IR since ir_write is low outside FETCH
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (bus.opcode == OP_RTYPE) begin
                    state_d = S_EXEC;
                end else if (is_mem_op(bus.opcode)) begin
                    state_d = S_MEM_ADDR;
                end else if ((bus.opcode == OP_BEQ) || (bus.opcode == OP_BNE)) begin
                    state_d = S_BRANCH;
                end else if (bus.opcode == OP_J) begin
                    state_d = S_JUMP;
                end else begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
`else
                    state_d = S_FETCH;
`endif
                end
            end
            S_MEM_ADDR: state_d = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (bus.mem_ready) state_d = S_MEM_WB;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   if (bus.mem_ready) state_d = S_FETCH;
            S_EXEC:     state_d = S_R_WB;
            S_R_WB:     state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_IDLE;
        endcase
    end

    // Output decode from current state
    multicycle_output_decode u_decode (
        .state_i     (state_q),
        .mem_ready_i (bus.mem_ready),
        .zero_sel_i  (bus.opcode[0]),
        .ctrl_o      (ctrl)
    );

    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.zero_inv      = ctrl.zero_inv;
    assign bus.iord          = ctrl.iord;
    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.reg_dst       = ctrl.reg_dst;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.alu_op        = ctrl.alu_op;
    assign bus.pc_source     = ctrl.pc_source;
    assign bus.state         = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle scoreboard of state + control word.
// Latency: n/a.
// Backpressure: mem_ready wait states driven from the scoreboard entries.
module tb_multicycle_controller;
    import multicycle_controller_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    multicycle_controller_if bus();

    multicycle_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // One entry per clock: expected state plus the inputs applied in that cycle
    typedef struct packed {
        logic [3:0] st;
        logic       rdy;
        logic [5:0] op;
    } step_t;

    step_t sb_q[$];
    int    checks = 0;
    int    errors = 0;

    // Reference control word straight from the state table
    function automatic logic [20:0] exp_vec(input logic [3:0] st, input logic rdy, input logic [5:0] op);
        logic pw, pwc, zi, iord, mr, mw, irw, m2r, rd, rw, sa;
        logic [1:0] sb, ao, ps;
        {pw, pwc, zi, iord, mr, mw, irw, m2r, rd, rw, sa} = '0;
        sb = 2'b00; ao = 2'b00; ps = 2'b00;
        case (st)
            4'd1:  begin mr = 1'b1; sb = 2'b01; irw = rdy; pw = rdy; end
            4'd2:  begin sb = 2'b11; end
            4'd3:  begin sa = 1'b1; sb = 2'b10; end
            4'd4:  begin mr = 1'b1; iord = 1'b1; end
            4'd5:  begin rw = 1'b1; m2r = 1'b1; end
            4'd6:  begin mw = 1'b1; iord = 1'b1; end
            4'd7:  begin sa = 1'b1; ao = 2'b10; end
            4'd8:  begin rw = 1'b1; rd = 1'b1; end
            4'd9:  begin sa = 1'b1; ao = 2'b01; pwc = 1'b1; ps = 2'b01; zi = op[0]; end
            4'd10: begin pw = 1'b1; ps = 2'b10; end
            default: ;
        endcase
        return {st, pw, pwc, zi, iord, mr, mw, irw, m2r, rd, rw, sa, sb, ao, ps};
    endfunction

    function automatic logic [20:0] dut_vec();
        return {bus.state, bus.pc_write, bus.pc_write_cond, bus.zero_inv, bus.iord,
                bus.mem_read, bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_source};
    endfunction

    task automatic push(input logic [3:0] st, input logic rdy, input logic [5:0] op);
        step_t s;
        s.st = st; s.rdy = rdy; s.op = op;
        sb_q.push_back(s);
    endtask

    // Drain the scoreboard: one entry per cycle, inputs at negedge, sample 1 ns later
    task automatic run_sb(input string name);
        step_t       s;
        logic [20:0] got;
        logic [20:0] exp;
        int          idx = 0;
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            @(negedge clk);
            bus.opcode    = s.op;
            bus.mem_ready = s.rdy;
            #1;
            got = dut_vec();
            exp = exp_vec(s.st, s.rdy, s.op);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s step%0d: got state=%0d ctrl=%h, expected state=%0d ctrl=%h",
                         name, idx, got[20:17], got[16:0], exp[20:17], exp[16:0]);
            end
            checks++;
            if ((bus.mem_read && bus.mem_write) || (bus.reg_write && bus.pc_write)) begin
                errors++;
                $display("FAIL %s_exclusive step%0d: rd=%b wr=%b reg_write=%b pc_write=%b, expected no overlap",
                         name, idx, bus.mem_read, bus.mem_write, bus.reg_write, bus.pc_write);
            end
            idx++;
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (dut_vec() !== 21'd0) begin
            errors++;
            $display("FAIL %s: got %h, expected all-zero outputs in IDLE", name, dut_vec());
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.mem_ready = 1'b1;
        bus.opcode    = 6'h00;
        repeat (2) @(negedge clk);
        #1 check_zero("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_zero("reset_release_idle");
    endtask

    task automatic test_lw();
        push(4'd1, 1'b1, OP_LW);
        push(4'd2, 1'b1, OP_LW);
        push(4'd3, 1'b1, OP_LW);
        push(4'd4, 1'b1, OP_LW);
        push(4'd5, 1'b1, OP_LW);
        run_sb("lw");
    endtask

    task automatic test_sw_wait();
        push(4'd1, 1'b0, OP_SW);   // fetch wait: no ir_write/pc_write
        push(4'd1, 1'b1, OP_SW);
        push(4'd2, 1'b1, OP_SW);
        push(4'd3, 1'b1, OP_SW);
        for (int i = 0; i < 3; i++) push(4'd6, 1'b0, OP_SW);
        push(4'd6, 1'b1, OP_SW);
        run_sb("sw_wait");
    endtask

    task automatic test_branch();
        push(4'd1, 1'b1, OP_BEQ);
        push(4'd2, 1'b1, OP_BEQ);
        push(4'd9, 1'b1, OP_BEQ);
        push(4'd1, 1'b1, OP_BNE);
        push(4'd2, 1'b1, OP_BNE);
        push(4'd9, 1'b1, OP_BNE);
        run_sb("branch");
    endtask

    task automatic test_jump_rtype();
        push(4'd1, 1'b1, OP_J);
        push(4'd2, 1'b1, OP_J);
        push(4'd10, 1'b1, OP_J);
        push(4'd1, 1'b1, OP_RTYPE);
        push(4'd2, 1'b1, OP_RTYPE);
        push(4'd7, 1'b1, OP_RTYPE);
        push(4'd8, 1'b1, OP_RTYPE);
        run_sb("jump_rtype");
    endtask

    task automatic test_illegal();
        push(4'd1, 1'b1, 6'h3F);
        push(4'd2, 1'b1, 6'h3F);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        push(4'd11, 1'b1, 6'h3F);
        push(4'd11, 1'b0, 6'h3F);
        push(4'd11, 1'b1, OP_RTYPE);
        run_sb("illegal_trap");
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_zero("trap_reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_zero("trap_reset_idle");
`else
        push(4'd1, 1'b1, OP_RTYPE);  // NOP: straight back to FETCH
        push(4'd2, 1'b1, OP_RTYPE);
        push(4'd7, 1'b1, OP_RTYPE);
        push(4'd8, 1'b1, OP_RTYPE);
        run_sb("illegal_nop");
`endif
    endtask

    task automatic test_async_reset();
        push(4'd1, 1'b1, OP_LW);
        push(4'd2, 1'b1, OP_LW);
        push(4'd3, 1'b1, OP_LW);
        push(4'd4, 1'b0, OP_LW);
        run_sb("async_pre");
        // Mid-cycle, well away from the next rising edge
        rst_n = 1'b0;
        #1 check_zero("async_reset_no_edge");
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_zero("async_reset_idle");
        push(4'd1, 1'b1, OP_J);
        push(4'd2, 1'b1, OP_J);
        push(4'd10, 1'b1, OP_J);
        run_sb("after_reset_j");
    endtask

    initial begin
        bus.opcode    = 6'h00;
        bus.mem_ready = 1'b1;
        test_reset();
        test_lw();
        test_sw_wait();
        test_branch();
        test_jump_rtype();
        test_illegal();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
